// File: rtl/flashattn_stage_sequencer.sv
// ap_ctrl_hs sequencer for the Read_Q -> (Read_K_and_V -> Attention_Loop) x N flash-attention
// dataflow, with per-stage busy-cycle counters, a KV tile index and a stall watchdog.
module flashattn_stage_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TILE_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    input  logic [TILE_W-1:0] num_kv_tiles,
    output logic              q_start,
    output logic              kv_start,
    output logic              attn_start,
    input  logic              q_ready,
    input  logic              kv_ready,
    input  logic              attn_ready,
    input  logic              q_done,
    input  logic              kv_done,
    input  logic              attn_done,
    output logic [TILE_W-1:0] tile_idx,
    output logic [2:0]        stage,
    output logic [CNT_W-1:0]  q_cycles,
    output logic [CNT_W-1:0]  kv_cycles,
    output logic [CNT_W-1:0]  attn_cycles,
    output logic              err,
    input  logic              clear_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        Q_RUN    = 3'd1,
        KV_RUN   = 3'd2,
        ATTN_RUN = 3'd3,
        FIN      = 3'd4,
        ERR      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TILE_W:0]   TILE_ONE = (TILE_W + 1)'(1);
    localparam logic [31:0]       WD_LIMIT = 32'(TIMEOUT);

    state_t             state_q, state_d;
    logic [TILE_W-1:0]  n_q, n_d;
    logic [TILE_W-1:0]  tile_q, tile_d;
    logic [CNT_W-1:0]   q_cyc_q, q_cyc_d;
    logic [CNT_W-1:0]   kv_cyc_q, kv_cyc_d;
    logic [CNT_W-1:0]   attn_cyc_q, attn_cyc_d;
    logic [31:0]        wd_cnt_q, wd_cnt_d;
    logic               q_start_q, q_start_d;
    logic               kv_start_q, kv_start_d;
    logic               attn_start_q, attn_start_d;
    logic               err_q, err_d;

    logic               run_start, run_ready, run_done;
    logic               stage_done, wd_expired;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        run_start = 1'b0;
        run_ready = 1'b0;
        run_done  = 1'b0;
        case (state_q)
            Q_RUN:    begin run_start = q_start_q;    run_ready = q_ready;    run_done = q_done;    end
            KV_RUN:   begin run_start = kv_start_q;   run_ready = kv_ready;   run_done = kv_done;   end
            ATTN_RUN: begin run_start = attn_start_q; run_ready = attn_ready; run_done = attn_done; end
            default:  ;
        endcase
        // A done only counts once the child has taken its start (same-cycle ready is fine).
        stage_done = run_done && (run_ready || !run_start);
        wd_expired = (TIMEOUT != 0) && ((wd_cnt_q + 32'd1) >= WD_LIMIT);
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        tile_d       = tile_q;
        q_cyc_d      = q_cyc_q;
        kv_cyc_d     = kv_cyc_q;
        attn_cyc_d   = attn_cyc_q;
        wd_cnt_d     = wd_cnt_q;
        q_start_d    = q_start_q;
        kv_start_d   = kv_start_q;
        attn_start_d = attn_start_q;
        err_d        = err_q;

        if (state_q == Q_RUN)    q_cyc_d    = sat_inc(q_cyc_q);
        if (state_q == KV_RUN)   kv_cyc_d   = sat_inc(kv_cyc_q);
        if (state_q == ATTN_RUN) attn_cyc_d = sat_inc(attn_cyc_q);

        if (state_q == Q_RUN    && q_ready)    q_start_d    = 1'b0;
        if (state_q == KV_RUN   && kv_ready)   kv_start_d   = 1'b0;
        if (state_q == ATTN_RUN && attn_ready) attn_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    n_d        = num_kv_tiles;
                    tile_d     = '0;
                    q_cyc_d    = '0;
                    kv_cyc_d   = '0;
                    attn_cyc_d = '0;
                    wd_cnt_d   = '0;
                    q_start_d  = 1'b1;
                    state_d    = Q_RUN;
                end
            end
            Q_RUN, KV_RUN, ATTN_RUN: begin
                if (stage_done) begin
                    wd_cnt_d     = '0;
                    q_start_d    = 1'b0;
                    kv_start_d   = 1'b0;
                    attn_start_d = 1'b0;
                    if (state_q == Q_RUN) begin
                        if (n_q != '0) begin
                            kv_start_d = 1'b1;
                            state_d    = KV_RUN;
                        end else begin
                            state_d    = FIN;
                        end
                    end else if (state_q == KV_RUN) begin
                        attn_start_d = 1'b1;
                        state_d      = ATTN_RUN;
                    end else if (({1'b0, tile_q} + TILE_ONE) < {1'b0, n_q}) begin
                        tile_d     = tile_q + TILE_ONE[TILE_W-1:0];
                        kv_start_d = 1'b1;
                        state_d    = KV_RUN;
                    end else begin
                        state_d    = FIN;
                    end
                end else if (wd_expired) begin
                    q_start_d    = 1'b0;
                    kv_start_d   = 1'b0;
                    attn_start_d = 1'b0;
                    err_d        = 1'b1;
                    state_d      = ERR;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            FIN: state_d = IDLE;
            ERR: begin
                if (clear_err) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            tile_q       <= '0;
            q_cyc_q      <= '0;
            kv_cyc_q     <= '0;
            attn_cyc_q   <= '0;
            wd_cnt_q     <= '0;
            q_start_q    <= 1'b0;
            kv_start_q   <= 1'b0;
            attn_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            tile_q       <= tile_d;
            q_cyc_q      <= q_cyc_d;
            kv_cyc_q     <= kv_cyc_d;
            attn_cyc_q   <= attn_cyc_d;
            wd_cnt_q     <= wd_cnt_d;
            q_start_q    <= q_start_d;
            kv_start_q   <= kv_start_d;
            attn_start_q <= attn_start_d;
            err_q        <= err_d;
        end
    end

    assign ap_done     = (state_q == FIN);
    assign ap_ready    = (state_q == FIN);
    assign ap_idle     = (state_q == IDLE);
    assign q_start     = q_start_q;
    assign kv_start    = kv_start_q;
    assign attn_start  = attn_start_q;
    assign tile_idx    = tile_q;
    assign stage       = state_q;
    assign q_cycles    = q_cyc_q;
    assign kv_cycles   = kv_cyc_q;
    assign attn_cycles = attn_cyc_q;
    assign err         = err_q;

endmodule

// File: tb/tb_flashattn_stage_sequencer.sv
// Directed bench for flashattn_stage_sequencer: child handshakes are played at negedges,
// outputs are sampled at negedges against hand-computed values.
module tb_flashattn_stage_sequencer;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;
    logic [7:0]  num_kv_tiles;
    logic        q_start, kv_start, attn_start;
    logic        q_ready, kv_ready, attn_ready;
    logic        q_done, kv_done, attn_done;
    logic [7:0]  tile_idx;
    logic [2:0]  stage;
    logic [31:0] q_cycles, kv_cycles, attn_cycles;
    logic        err;
    logic        clear_err;

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;

    flashattn_stage_sequencer #(.CNT_W(32), .TILE_W(8), .TIMEOUT(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .num_kv_tiles(num_kv_tiles),
        .q_start(q_start), .kv_start(kv_start), .attn_start(attn_start),
        .q_ready(q_ready), .kv_ready(kv_ready), .attn_ready(attn_ready),
        .q_done(q_done), .kv_done(kv_done), .attn_done(attn_done),
        .tile_idx(tile_idx), .stage(stage),
        .q_cycles(q_cycles), .kv_cycles(kv_cycles), .attn_cycles(attn_cycles),
        .err(err), .clear_err(clear_err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Counts ap_done pulses so a doubled or missing completion is caught.
    always @(negedge ap_clk) if (ap_done === 1'b1) doneCount <= doneCount + 1;

    task automatic tick();
        @(negedge ap_clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic startOf(input int sel);
        case (sel)
            0:       return q_start;
            1:       return kv_start;
            default: return attn_start;
        endcase
    endfunction

    task automatic driveChild(input int sel, input logic rdy, input logic dn);
        case (sel)
            0:       begin q_ready = rdy;    q_done = dn;    end
            1:       begin kv_ready = rdy;   kv_done = dn;   end
            default: begin attn_ready = rdy; attn_done = dn; end
        endcase
    endtask

    // Waits for child 'sel' to be started, then answers ready after rd cycles and done dd cycles later.
    // Returns at the negedge of the first cycle after done was sampled.
    task automatic applyStimulus(input int sel, input int rd, input int dd);
        bit found = 0;
        for (int i = 0; i < 64; i++) begin
            if (startOf(sel) === 1'b1) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) begin
            checkOutput("start_wait", 32'(startOf(sel)), 32'd1);
        end else begin
            checkOutput("start_onehot", 32'({q_start, kv_start, attn_start}), 32'(3'b100 >> sel));
            checkOutput("stage_run", 32'(stage), 32'(sel + 1));
            for (int k = 0; k <= rd + dd; k++) begin
                driveChild(sel, k == rd, k == rd + dd);
                tick();
            end
            driveChild(sel, 1'b0, 1'b0);
        end
    endtask

    task automatic beginTxn(input logic [7:0] tiles);
        ap_start     = 1'b1;
        num_kv_tiles = tiles;
        tick();
        ap_start     = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0; num_kv_tiles = 8'd0; clear_err = 1'b0;
        q_ready = 1'b0; kv_ready = 1'b0; attn_ready = 1'b0;
        q_done = 1'b0;  kv_done = 1'b0;  attn_done = 1'b0;

        #12;
        checkOutput("rst_stage", 32'(stage), 32'd0);
        checkOutput("rst_idle", 32'(ap_idle), 32'd1);
        checkOutput("rst_starts", 32'({q_start, kv_start, attn_start}), 32'd0);
        checkOutput("rst_done", 32'({ap_done, ap_ready, err}), 32'd0);
        checkOutput("rst_cnt", q_cycles | kv_cycles | attn_cycles, 32'd0);
        ap_rst_n = 1'b1;
        tick();

        // Basic run with two KV tiles
        beginTxn(8'd2);
        checkOutput("t1_not_idle", 32'(ap_idle), 32'd0);
        applyStimulus(0, 0, 3);
        applyStimulus(1, 0, 3);
        checkOutput("t1_tile0", 32'(tile_idx), 32'd0);
        applyStimulus(2, 0, 3);
        checkOutput("t1_tile1", 32'(tile_idx), 32'd1);
        applyStimulus(1, 0, 3);
        applyStimulus(2, 0, 3);
        checkOutput("t1_fin_stage", 32'(stage), 32'd4);
        checkOutput("t1_done_ready", 32'({ap_done, ap_ready}), 32'd3);
        tick();
        checkOutput("t1_idle_after", 32'({ap_idle, ap_done}), 32'd2);
        checkOutput("t1_q_cycles", q_cycles, 32'd4);
        checkOutput("t1_kv_cycles", kv_cycles, 32'd8);
        checkOutput("t1_attn_cycles", attn_cycles, 32'd8);
        checkOutput("t1_tile_hold", 32'(tile_idx), 32'd1);
        checkOutput("t1_done_pulses", 32'(doneCount), 32'd1);

        // Zero tiles: only Read_Q runs
        beginTxn(8'd0);
        applyStimulus(0, 0, 3);
        checkOutput("t2_fin", 32'({ap_done, stage}), 32'({1'b1, 3'd4}));
        checkOutput("t2_no_kv", 32'({kv_start, attn_start}), 32'd0);
        tick();
        checkOutput("t2_q_cycles", q_cycles, 32'd4);
        checkOutput("t2_kv_attn", kv_cycles | attn_cycles, 32'd0);
        checkOutput("t2_tile", 32'(tile_idx), 32'd0);

        // Single-cycle children
        beginTxn(8'd1);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(2, 0, 0);
        checkOutput("t3_fin", 32'({ap_done, stage}), 32'({1'b1, 3'd4}));
        tick();
        checkOutput("t3_q_cycles", q_cycles, 32'd1);
        checkOutput("t3_kv_cycles", kv_cycles, 32'd1);
        checkOutput("t3_attn_cycles", attn_cycles, 32'd1);
        checkOutput("t3_done_pulses", 32'(doneCount), 32'd3);

        // Watchdog: Attention_Loop never finishes
        beginTxn(8'd1);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        checkOutput("t4_attn_start", 32'(attn_start), 32'd1);
        attn_ready = 1'b1;
        tick();
        attn_ready = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        checkOutput("t4_still_run", 32'(stage), 32'd3);
        tick();
        checkOutput("t4_err_stage", 32'(stage), 32'd5);
        checkOutput("t4_err_flag", 32'(err), 32'd1);
        checkOutput("t4_starts_low", 32'({q_start, kv_start, attn_start}), 32'd0);
        checkOutput("t4_attn_cycles", attn_cycles, 32'd16);
        ap_start = 1'b1; attn_done = 1'b1; attn_ready = 1'b1;
        tick(); tick(); tick();
        checkOutput("t4_err_sticky", 32'({err, stage}), 32'({1'b1, 3'd5}));
        checkOutput("t4_frozen", attn_cycles, 32'd16);
        checkOutput("t4_no_done", 32'(doneCount), 32'd3);
        ap_start = 1'b0; attn_done = 1'b0; attn_ready = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checkOutput("t4_cleared", 32'({err, ap_idle, stage}), 32'({1'b0, 1'b1, 3'd0}));

        // Asynchronous reset during the second KV tile
        beginTxn(8'd2);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(2, 0, 1);
        checkOutput("t5_pre_tile", 32'(tile_idx), 32'd1);
        checkOutput("t5_pre_kv", 32'(kv_start), 32'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_stage", 32'({ap_idle, stage}), 32'({1'b1, 3'd0}));
        checkOutput("t5_rst_kv", 32'(kv_start), 32'd0);
        checkOutput("t5_rst_tile", 32'(tile_idx), 32'd0);
        checkOutput("t5_rst_cnt", q_cycles | kv_cycles | attn_cycles, 32'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        beginTxn(8'd1);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(2, 0, 1);
        checkOutput("t5_fin", 32'({ap_done, stage}), 32'({1'b1, 3'd4}));
        tick();
        checkOutput("t5_attn_cycles", attn_cycles, 32'd2);
        checkOutput("t5_done_pulses", 32'(doneCount), 32'd4);

        // Back-to-back with a spurious kv_done during Read_Q
        ap_start = 1'b1; num_kv_tiles = 8'd1;
        tick();
        kv_done = 1'b1;
        tick();
        kv_done = 1'b0;
        num_kv_tiles = 8'd5;
        checkOutput("t6_ignore_spurious", 32'({q_start, stage}), 32'({1'b1, 3'd1}));
        applyStimulus(0, 0, 2);
        applyStimulus(1, 0, 1);
        applyStimulus(2, 0, 1);
        checkOutput("t6_fin1", 32'({ap_done, stage}), 32'({1'b1, 3'd4}));
        checkOutput("t6_tile_latched", 32'(tile_idx), 32'd0);
        num_kv_tiles = 8'd1;
        tick();
        checkOutput("t6_idle_gap", 32'({ap_idle, q_start}), 32'd2);
        checkOutput("t6_q_cycles1", q_cycles, 32'd4);
        tick();
        checkOutput("t6_restart", 32'({q_start, stage}), 32'({1'b1, 3'd1}));
        ap_start = 1'b0;
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(2, 0, 1);
        checkOutput("t6_fin2", 32'({ap_done, stage}), 32'({1'b1, 3'd4}));
        tick();
        checkOutput("t6_q_cycles2", q_cycles, 32'd2);
        checkOutput("t6_done_pulses", 32'(doneCount), 32'd6);
        checkOutput("t6_idle_end", 32'(ap_idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
